// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl
// Brief    : Pipeline sequencer for the 5-stage core. Resolves data-memory
//            freezes, taken-branch redirects (immediate or deferred until the
//            IF fetch completes) and load-use hazards. Also keeps saturating
//            stall/redirect performance counters.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_branch_taken,
    input  logic [XLEN-1:0]  ex_branch_target,
    input  logic             mem_req,
    input  logic             mem_ready,
    input  logic             imem_ready,
    output logic             stall,
    output logic             stall_id,
    output logic             freeze,
    output logic             bubble_ex,
    output logic             flush_id,
    output logic             flush_ex,
    output logic             branch_taken,
    output logic [XLEN-1:0]  branch_target,
    output logic             redirect_pending,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] redirect_count
);

    typedef enum logic [0:0] {
        RUN     = 1'b0,
        IF_WAIT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t            state_q, state_d;
    logic [XLEN-1:0]   pend_target_q, pend_target_d;
    logic [CNT_W-1:0]  stall_cycles_q, stall_cycles_d;
    logic [CNT_W-1:0]  redirect_count_q, redirect_count_d;

    logic mem_wait;
    logic load_use;

    // Data memory still busy: the whole back end must hold.
    assign mem_wait = mem_req & ~mem_ready;

    // Load in EX whose result a source operand of the ID instruction needs.
    assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                      ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                       (id_uses_rs2 && (id_rs2 == ex_rd)));

    // Next state and control outputs; priority is freeze > branch > load-use.
    always_comb begin
        state_d          = state_q;
        pend_target_d    = pend_target_q;
        stall            = 1'b0;
        stall_id         = 1'b0;
        freeze           = 1'b0;
        bubble_ex        = 1'b0;
        flush_id         = 1'b0;
        flush_ex         = 1'b0;
        branch_taken     = 1'b0;
        branch_target    = '0;
        redirect_pending = 1'b0;

        if (rst) begin
            state_d       = RUN;
            pend_target_d = '0;
        end else begin
            redirect_pending = (state_q == IF_WAIT);
            if (mem_wait) begin
                // EX is frozen and will re-present any branch later.
                stall    = 1'b1;
                stall_id = 1'b1;
                freeze   = 1'b1;
            end else begin
                case (state_q)
                    RUN: begin
                        if (ex_branch_taken) begin
                            flush_id = 1'b1;
                            flush_ex = 1'b1;
                            if (imem_ready) begin
                                branch_taken  = 1'b1;
                                branch_target = ex_branch_target;
                            end else begin
                                pend_target_d = ex_branch_target;
                                state_d       = IF_WAIT;
                            end
                        end else if (load_use) begin
                            stall     = 1'b1;
                            stall_id  = 1'b1;
                            bubble_ex = 1'b1;
                        end
                    end
                    IF_WAIT: begin
                        // Drop the wrong-path fetch until IF accepts the redirect.
                        flush_id = 1'b1;
                        if (imem_ready) begin
                            branch_taken  = 1'b1;
                            branch_target = pend_target_q;
                            state_d       = RUN;
                        end
                    end
                    default: state_d = RUN;
                endcase
            end
        end
    end

    // Saturating event counters.
    always_comb begin
        stall_cycles_d   = stall_cycles_q;
        redirect_count_d = redirect_count_q;
        if (stall && (stall_cycles_q != CNT_MAX)) begin
            stall_cycles_d = stall_cycles_q + CNT_ONE;
        end
        if (branch_taken && (redirect_count_q != CNT_MAX)) begin
            redirect_count_d = redirect_count_q + CNT_ONE;
        end
    end

    // State, pending target and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= RUN;
            pend_target_q    <= '0;
            stall_cycles_q   <= '0;
            redirect_count_q <= '0;
        end else begin
            state_q          <= state_d;
            pend_target_q    <= pend_target_d;
            stall_cycles_q   <= stall_cycles_d;
            redirect_count_q <= redirect_count_d;
        end
    end

    assign stall_cycles   = stall_cycles_q;
    assign redirect_count = redirect_count_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_ctrl
// Brief    : Directed self-checking bench for hazard_ctrl (4-bit counters).
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

    localparam int XLEN  = 32;
    localparam int CNT_W = 4;

    logic             clk;
    logic             rst;
    logic [4:0]       id_rs1, id_rs2, ex_rd;
    logic             id_uses_rs1, id_uses_rs2, ex_mem_read;
    logic             ex_branch_taken;
    logic [XLEN-1:0]  ex_branch_target;
    logic             mem_req, mem_ready, imem_ready;
    logic             stall, stall_id, freeze, bubble_ex, flush_id, flush_ex;
    logic             branch_taken;
    logic [XLEN-1:0]  branch_target;
    logic             redirect_pending;
    logic [CNT_W-1:0] stall_cycles, redirect_count;

    logic [6:0] ctl;
    int         n_checks;
    int         n_fail;
    logic [CNT_W-1:0] exp_stall;
    logic [CNT_W-1:0] exp_redir;

    // {stall, stall_id, freeze, bubble_ex, flush_id, flush_ex, branch_taken}
    assign ctl = {stall, stall_id, freeze, bubble_ex, flush_id, flush_ex, branch_taken};

    hazard_ctrl #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk              (clk),
        .rst              (rst),
        .id_rs1           (id_rs1),
        .id_rs2           (id_rs2),
        .id_uses_rs1      (id_uses_rs1),
        .id_uses_rs2      (id_uses_rs2),
        .ex_rd            (ex_rd),
        .ex_mem_read      (ex_mem_read),
        .ex_branch_taken  (ex_branch_taken),
        .ex_branch_target (ex_branch_target),
        .mem_req          (mem_req),
        .mem_ready        (mem_ready),
        .imem_ready       (imem_ready),
        .stall            (stall),
        .stall_id         (stall_id),
        .freeze           (freeze),
        .bubble_ex        (bubble_ex),
        .flush_id         (flush_id),
        .flush_ex         (flush_ex),
        .branch_taken     (branch_taken),
        .branch_target    (branch_target),
        .redirect_pending (redirect_pending),
        .stall_cycles     (stall_cycles),
        .redirect_count   (redirect_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
        id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; ex_mem_read = 1'b0;
        ex_branch_taken = 1'b0; ex_branch_target = '0;
        mem_req = 1'b0; mem_ready = 1'b0; imem_ready = 1'b1;
    endtask

    task automatic set_load_use(input logic [4:0] rd);
        ex_mem_read = 1'b1; ex_rd = rd; id_rs2 = rd; id_uses_rs2 = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        id_rs1 = 5'd3; id_rs2 = 5'd3; ex_rd = 5'd3;
        id_uses_rs1 = 1'b1; id_uses_rs2 = 1'b1; ex_mem_read = 1'b1;
        ex_branch_taken = 1'b1; ex_branch_target = 32'h1234;
        mem_req = 1'b1; mem_ready = 1'b0; imem_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); #1;
            n_checks++;
            if (ctl !== 7'b0 || branch_target !== '0 || redirect_pending !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_outputs: ctl=%b tgt=%h pend=%b, required ctl=0 tgt=0 pend=0",
                         ctl, branch_target, redirect_pending);
            end
        end
        @(negedge clk);
        idle_inputs();
        rst = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (stall_cycles !== 4'd0 || redirect_count !== 4'd0 || redirect_pending !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: stall_cycles=%0d redir=%0d pend=%b, required 0 0 0",
                     stall_cycles, redirect_count, redirect_pending);
        end
        exp_stall = 4'd0; exp_redir = 4'd0;
    endtask

    task automatic test_load_use();
        // rs2 match -> one stall cycle with bubble
        @(negedge clk); idle_inputs(); set_load_use(5'd5); #1;
        n_checks++;
        if (ctl !== 7'b1101000) begin
            n_fail++;
            $display("FAIL load_use_rs2: ctl=%b, required 1101000", ctl);
        end
        @(posedge clk); #1; exp_stall = 4'd1;
        n_checks++;
        if (stall_cycles !== exp_stall) begin
            n_fail++;
            $display("FAIL load_use_count: stall_cycles=%0d, required %0d", stall_cycles, exp_stall);
        end
        // ex_rd = x0 never hazards
        @(negedge clk); idle_inputs(); set_load_use(5'd0); #1;
        n_checks++;
        if (ctl !== 7'b0) begin
            n_fail++;
            $display("FAIL load_use_x0: ctl=%b, required 0000000", ctl);
        end
        // rs1 match
        @(negedge clk); idle_inputs();
        ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd7; id_uses_rs1 = 1'b1; #1;
        n_checks++;
        if (ctl !== 7'b1101000) begin
            n_fail++;
            $display("FAIL load_use_rs1: ctl=%b, required 1101000", ctl);
        end
        @(posedge clk); #1; exp_stall = 4'd2;
        // register matches but the operand is not read
        @(negedge clk); idle_inputs(); set_load_use(5'd9); id_uses_rs2 = 1'b0; #1;
        n_checks++;
        if (ctl !== 7'b0) begin
            n_fail++;
            $display("FAIL load_use_unused: ctl=%b, required 0000000", ctl);
        end
        // non-load in EX
        @(negedge clk); idle_inputs(); set_load_use(5'd9); ex_mem_read = 1'b0; #1;
        n_checks++;
        if (ctl !== 7'b0) begin
            n_fail++;
            $display("FAIL load_use_noload: ctl=%b, required 0000000", ctl);
        end
        @(posedge clk); #1;
        n_checks++;
        if (stall_cycles !== exp_stall) begin
            n_fail++;
            $display("FAIL load_use_count2: stall_cycles=%0d, required %0d", stall_cycles, exp_stall);
        end
    endtask

    task automatic test_immediate_redirect();
        // load-use also present: branch must win
        @(negedge clk); idle_inputs(); set_load_use(5'd5);
        ex_branch_taken = 1'b1; ex_branch_target = 32'h20; imem_ready = 1'b1; #1;
        n_checks++;
        if (ctl !== 7'b0000111 || branch_target !== 32'h20) begin
            n_fail++;
            $display("FAIL imm_redirect: ctl=%b tgt=%h, required 0000111 tgt=20", ctl, branch_target);
        end
        @(posedge clk); #1; exp_redir = 4'd1;
        n_checks++;
        if (redirect_count !== exp_redir || redirect_pending !== 1'b0 || stall_cycles !== exp_stall) begin
            n_fail++;
            $display("FAIL imm_redirect_cnt: redir=%0d pend=%b stalls=%0d, required %0d 0 %0d",
                     redirect_count, redirect_pending, stall_cycles, exp_redir, exp_stall);
        end
    endtask

    task automatic test_deferred_redirect();
        @(negedge clk); idle_inputs();
        ex_branch_taken = 1'b1; ex_branch_target = 32'h40; imem_ready = 1'b0; #1;
        n_checks++;
        if (ctl !== 7'b0000110 || branch_target !== '0) begin
            n_fail++;
            $display("FAIL defer_first: ctl=%b tgt=%h, required 0000110 tgt=0", ctl, branch_target);
        end
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); idle_inputs(); imem_ready = 1'b0;
            ex_branch_target = 32'h99; #1;
            n_checks++;
            if (ctl !== 7'b0000100 || branch_target !== '0 || redirect_pending !== 1'b1) begin
                n_fail++;
                $display("FAIL defer_wait: ctl=%b tgt=%h pend=%b, required 0000100 tgt=0 pend=1",
                         ctl, branch_target, redirect_pending);
            end
            @(posedge clk);
        end
        @(negedge clk); idle_inputs(); imem_ready = 1'b1; #1;
        n_checks++;
        if (ctl !== 7'b0000101 || branch_target !== 32'h40) begin
            n_fail++;
            $display("FAIL defer_apply: ctl=%b tgt=%h, required 0000101 tgt=40", ctl, branch_target);
        end
        @(posedge clk); #1; exp_redir = 4'd2;
        n_checks++;
        if (redirect_pending !== 1'b0 || redirect_count !== exp_redir) begin
            n_fail++;
            $display("FAIL defer_done: pend=%b redir=%0d, required 0 %0d",
                     redirect_pending, redirect_count, exp_redir);
        end
    endtask

    task automatic test_freeze_priority();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); idle_inputs(); set_load_use(5'd5);
            ex_branch_taken = 1'b1; ex_branch_target = 32'h80; imem_ready = 1'b1;
            mem_req = 1'b1; mem_ready = 1'b0; #1;
            n_checks++;
            if (ctl !== 7'b1110000 || branch_target !== '0) begin
                n_fail++;
                $display("FAIL freeze_cycle%0d: ctl=%b tgt=%h, required 1110000 tgt=0", i, ctl, branch_target);
            end
            @(posedge clk);
        end
        exp_stall = 4'd6;
        @(negedge clk); mem_ready = 1'b1; #1;
        n_checks++;
        if (ctl !== 7'b0000111 || branch_target !== 32'h80) begin
            n_fail++;
            $display("FAIL freeze_release: ctl=%b tgt=%h, required 0000111 tgt=80", ctl, branch_target);
        end
        @(posedge clk); #1; exp_redir = 4'd3;
        n_checks++;
        if (stall_cycles !== exp_stall || redirect_count !== exp_redir) begin
            n_fail++;
            $display("FAIL freeze_counts: stalls=%0d redir=%0d, required %0d %0d",
                     stall_cycles, redirect_count, exp_stall, exp_redir);
        end
    endtask

    task automatic test_back_to_back();
        // freeze arriving while a redirect is pending holds the saved target
        @(negedge clk); idle_inputs();
        ex_branch_taken = 1'b1; ex_branch_target = 32'h100; imem_ready = 1'b0;
        @(posedge clk);
        @(negedge clk); idle_inputs(); imem_ready = 1'b1;
        mem_req = 1'b1; mem_ready = 1'b0; #1;
        n_checks++;
        if (ctl !== 7'b1110000 || redirect_pending !== 1'b1) begin
            n_fail++;
            $display("FAIL wait_freeze: ctl=%b pend=%b, required 1110000 pend=1", ctl, redirect_pending);
        end
        @(posedge clk); exp_stall = 4'd7;
        @(negedge clk); idle_inputs(); imem_ready = 1'b1; #1;
        n_checks++;
        if (ctl !== 7'b0000101 || branch_target !== 32'h100) begin
            n_fail++;
            $display("FAIL wait_after_freeze: ctl=%b tgt=%h, required 0000101 tgt=100", ctl, branch_target);
        end
        @(posedge clk); exp_redir = 4'd4;
        // next cycle a fresh load-use is honoured in RUN
        @(negedge clk); idle_inputs(); set_load_use(5'd12); #1;
        n_checks++;
        if (ctl !== 7'b1101000) begin
            n_fail++;
            $display("FAIL b2b_load_use: ctl=%b, required 1101000", ctl);
        end
        @(posedge clk); #1; exp_stall = 4'd8;
        n_checks++;
        if (stall_cycles !== exp_stall || redirect_count !== exp_redir) begin
            n_fail++;
            $display("FAIL b2b_counts: stalls=%0d redir=%0d, required %0d %0d",
                     stall_cycles, redirect_count, exp_stall, exp_redir);
        end
    endtask

    task automatic test_saturation();
        // 8 -> 15 takes 7 cycles; 5 more must hold at 15
        for (int i = 0; i < 12; i++) begin
            @(negedge clk); idle_inputs(); set_load_use(5'd5);
            @(posedge clk);
        end
        #1;
        n_checks++;
        if (stall_cycles !== 4'hF) begin
            n_fail++;
            $display("FAIL stall_saturate: stall_cycles=%0d, required 15", stall_cycles);
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk); idle_inputs();
        ex_branch_taken = 1'b1; ex_branch_target = 32'h60; imem_ready = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (redirect_pending !== 1'b1) begin
            n_fail++;
            $display("FAIL arst_pending: pend=%b, required 1", redirect_pending);
        end
        @(negedge clk); idle_inputs(); imem_ready = 1'b0; #2;
        rst = 1'b1; imem_ready = 1'b1; #1;
        n_checks++;
        if (ctl !== 7'b0 || redirect_pending !== 1'b0 || stall_cycles !== 4'd0 || redirect_count !== 4'd0) begin
            n_fail++;
            $display("FAIL arst_mid: ctl=%b pend=%b stalls=%0d redir=%0d, required all 0",
                     ctl, redirect_pending, stall_cycles, redirect_count);
        end
        @(negedge clk); rst = 1'b0; #1;
        n_checks++;
        if (ctl !== 7'b0 || branch_target !== '0 || redirect_pending !== 1'b0) begin
            n_fail++;
            $display("FAIL arst_release: ctl=%b tgt=%h pend=%b, required 0 0 0",
                     ctl, branch_target, redirect_pending);
        end
        @(posedge clk); #1;
        n_checks++;
        if (redirect_count !== 4'd0) begin
            n_fail++;
            $display("FAIL arst_no_redirect: redir=%0d, required 0", redirect_count);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        exp_stall = '0;
        exp_redir = '0;
        idle_inputs();
        rst = 1'b1;
        test_reset();
        test_load_use();
        test_immediate_redirect();
        test_deferred_redirect();
        test_freeze_priority();
        test_back_to_back();
        test_saturation();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
